// File: rtl/match_run_detector.sv
// Compares two operands on every accepted sample, counts matches and mismatches,
// and tracks lock once RUN_LEN consecutive matches have been seen.
module match_run_detector #(
    parameter int W       = 2,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic             out_valid,
    output logic             match_q,
    output logic             lock,
    output logic [3:0]       run_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        LOSING = 2'd2
    } state_t;

    localparam logic [3:0]       RUN_MAX = 4'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       run_nxt;
    logic [CNT_W-1:0] match_nxt;
    logic [CNT_W-1:0] mismatch_nxt;
    logic [1:0]       rst_pipe;
    logic             rst_sync_n;
    logic             accept;
    logic             eq;

    // Assert asynchronously, release only after two clean clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_sync_n = rst_pipe[1];

    assign in_ready = ~clear;
    assign accept   = in_valid & in_ready;
    assign eq       = (x == y);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        run_nxt      = run_cnt;
        match_nxt    = match_cnt;
        mismatch_nxt = mismatch_cnt;
        if (accept) begin
            if (eq) begin
                if (run_cnt != RUN_MAX)   run_nxt   = run_cnt + 4'd1;
                if (match_cnt != CNT_MAX) match_nxt = match_cnt + CNT_ONE;
            end else begin
                run_nxt = 4'd0;
                if (mismatch_cnt != CNT_MAX) mismatch_nxt = mismatch_cnt + CNT_ONE;
            end
            unique case (state)
                SEARCH:  if (eq && run_nxt == RUN_MAX) state_nxt = LOCKED;
                LOCKED:  if (!eq) state_nxt = LOSING;
                LOSING:  state_nxt = eq ? LOCKED : SEARCH;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state        <= SEARCH;
            lock         <= 1'b0;
            run_cnt      <= 4'd0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            out_valid    <= 1'b0;
            match_q      <= 1'b0;
        end else if (clear) begin
            state        <= SEARCH;
            lock         <= 1'b0;
            run_cnt      <= 4'd0;
            match_cnt    <= '0;
            mismatch_cnt <= '0;
            out_valid    <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            state        <= state_nxt;
            // Registered from the next state so lock rises on the same edge as the state.
            lock         <= (state_nxt != SEARCH);
            run_cnt      <= run_nxt;
            match_cnt    <= match_nxt;
            mismatch_cnt <= mismatch_nxt;
            out_valid    <= accept;
            if (accept) match_q <= eq;
        end
    end

endmodule

// File: tb/tb_match_run_detector.sv
// Randomized and directed checks of match_run_detector against a behavioural model;
// a second instance with CNT_W=2 exercises counter saturation.
module tb_match_run_detector;

    localparam int W       = 2;
    localparam int RUN_LEN = 4;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [1:0] x;
    logic [1:0] y;

    logic       in_ready, out_valid, match_q, lock;
    logic [3:0] run_cnt;
    logic [7:0] match_cnt, mismatch_cnt;

    logic       s_in_ready, s_out_valid, s_match_q, s_lock;
    logic [3:0] s_run_cnt;
    logic [1:0] s_match_cnt, s_mismatch_cnt;

    int n_vec = 0;
    int n_err = 0;

    match_run_detector #(.W(W), .RUN_LEN(RUN_LEN), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .match_q(match_q), .lock(lock),
        .run_cnt(run_cnt), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt)
    );

    match_run_detector #(.W(W), .RUN_LEN(RUN_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
        .x(x), .y(y), .out_valid(s_out_valid), .match_q(s_match_q), .lock(s_lock),
        .run_cnt(s_run_cnt), .match_cnt(s_match_cnt), .mismatch_cnt(s_mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: unbounded totals, clipped only when compared.
    typedef enum {M_SEARCH, M_LOCKED, M_LOSING} mstate_t;
    mstate_t m_state;
    int      m_run, m_hits, m_misses;
    bit      m_ovalid, m_mq;

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_SEARCH; m_run = 0; m_hits = 0; m_misses = 0; m_ovalid = 0; m_mq = 0;
    endtask

    task automatic model_edge(input bit v, input bit c, input logic [1:0] xv, input logic [1:0] yv);
        bit hit;
        hit = (xv == yv);
        if (c) begin
            model_reset();
        end else if (v) begin
            m_ovalid = 1; m_mq = hit;
            if (hit) begin m_hits++; m_run++; end
            else     begin m_misses++; m_run = 0; end
            case (m_state)
                M_SEARCH: if (m_run >= RUN_LEN) m_state = M_LOCKED;
                M_LOCKED: if (!hit) m_state = M_LOSING;
                M_LOSING: m_state = hit ? M_LOCKED : M_SEARCH;
            endcase
        end else begin
            m_ovalid = 0;
        end
    endtask

    task automatic check_all();
        bit m_lock;
        m_lock = (m_state != M_SEARCH);
        check("out_valid", out_valid, m_ovalid);
        check("match_q", match_q, m_mq);
        check("lock", lock, m_lock);
        check("run_cnt", run_cnt, clip(m_run, RUN_LEN));
        check("match_cnt", match_cnt, clip(m_hits, 255));
        check("mismatch_cnt", mismatch_cnt, clip(m_misses, 255));
        check("sat_lock", s_lock, m_lock);
        check("sat_match_cnt", s_match_cnt, clip(m_hits, 3));
        check("sat_mismatch_cnt", s_mismatch_cnt, clip(m_misses, 3));
    endtask

    task automatic step(input bit v, input bit c, input logic [1:0] xv, input logic [1:0] yv);
        in_valid = v; clear = c; x = xv; y = yv;
        #1;
        check("in_ready", in_ready, !c);
        @(posedge clk);
        model_edge(v, c, xv, yv);
        #1;
        check_all();
    endtask

    // Assert rst_n between clock edges and check outputs before any edge arrives.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; x = '0; y = '0;
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 2'b00, 2'b00);

        // Mismatch then match.
        step(1, 0, 2'b01, 2'b00);
        check("d33_mq0", match_q, 0);
        step(1, 0, 2'b10, 2'b10);
        check("d33_mq1", match_q, 1);
        check("d33_mcnt", match_cnt, 1);
        check("d33_mmcnt", mismatch_cnt, 1);

        // Run ramp, lock, saturation of run_cnt and of the narrow counter.
        step(0, 1, 2'b00, 2'b00);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 2'(i), 2'(i));
            check("d34_run", run_cnt, i);
        end
        check("d34_lock", lock, 1);
        step(1, 0, 2'b11, 2'b11);
        check("d34_run_sat", run_cnt, 4);
        check("d36_sat_mcnt", s_match_cnt, 3);
        step(1, 0, 2'b00, 2'b00);
        step(1, 0, 2'b01, 2'b01);
        check("d38_pre_mcnt", match_cnt, 7);
        check("d38_pre_lock", lock, 1);

        // Asynchronous reset while locked.
        async_reset();
        check("d38_lock", lock, 0);
        check("d38_mcnt", match_cnt, 0);

        // Lock, then mismatch / match / mismatch / mismatch.
        for (int i = 0; i < 4; i++) step(1, 0, 2'b10, 2'b10);
        begin
            bit       d35_eq[4]  = '{0, 1, 0, 0};
            int       d35_run[4] = '{0, 1, 0, 0};
            bit       d35_lk[4]  = '{1, 1, 1, 0};
            for (int i = 0; i < 4; i++) begin
                step(1, 0, 2'b01, d35_eq[i] ? 2'b01 : 2'b10);
                check("d35_run", run_cnt, d35_run[i]);
                check("d35_lock", lock, d35_lk[i]);
            end
        end

        // Clear wins over a valid matching sample.
        for (int i = 0; i < 5; i++) step(1, 0, 2'b11, 2'b11);
        step(1, 1, 2'b11, 2'b11);
        check("d37_ovalid", out_valid, 0);
        check("d37_mcnt", match_cnt, 0);
        check("d37_lock", lock, 0);

        // Randomized traffic, biased towards matches so lock is reached often.
        for (int n = 0; n < 600; n++) begin
            logic [1:0] rx, ry;
            bit         rv, rc;
            rx = 2'($urandom);
            ry = ($urandom_range(0, 3) == 0) ? 2'($urandom) : rx;
            rv = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) async_reset();
            else step(rv, rc, rx, ry);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
